// File: rtl/ysyx_25030085_mem_pkg.sv
// Shared definitions for the NPC data-memory LSU: MemOp encodings (funct3),
// FSM states and the legality check for a load/store operation code.
package ysyx_25030085_mem_pkg;

   localparam logic [2:0] MEMOP_B  = 3'b000;
   localparam logic [2:0] MEMOP_H  = 3'b001;
   localparam logic [2:0] MEMOP_W  = 3'b010;
   localparam logic [2:0] MEMOP_BU = 3'b100;
   localparam logic [2:0] MEMOP_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } lsuState_e;

   // Stores have no unsigned variants; loads accept every RV32 width.
   function automatic logic is_legal_op(input logic [2:0] op, input logic is_store);
      if (is_store)
         return (op == MEMOP_B) || (op == MEMOP_H) || (op == MEMOP_W);
      return (op == MEMOP_B) || (op == MEMOP_H) || (op == MEMOP_W) ||
             (op == MEMOP_BU) || (op == MEMOP_HU);
   endfunction

endpackage

// File: rtl/ysyx_25030085_data_mem_lsu_load_align.sv
// Extracts the addressed byte/half/word from a memory word and applies the
// sign or zero extension selected by the load MemOp.
module ysyx_25030085_load_align
   import ysyx_25030085_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [2:0]  op,
   output logic [31:0] data
);

   logic [31:0] shifted;

   always_comb begin
      shifted = word >> {lane, 3'b000};
      case (op)
         MEMOP_B:  data = {{24{shifted[7]}}, shifted[7:0]};
         MEMOP_BU: data = {24'h0, shifted[7:0]};
         MEMOP_H:  data = {{16{shifted[15]}}, shifted[15:0]};
         MEMOP_HU: data = {16'h0, shifted[15:0]};
         MEMOP_W:  data = shifted;
         default:  data = '0;
      endcase
   end

endmodule

// File: rtl/ysyx_25030085_data_mem_lsu.sv
// Data memory behind the EX stage with a valid/ready load/store port,
// configurable response latency, range and alignment checking.
module ysyx_25030085_data_mem_lsu
   import ysyx_25030085_mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 65536,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int          LATENCY     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_re,
   input  logic        req_we,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   lsuState_e   stateReg, stateNext;
   logic [3:0]  cntReg, cntNext;

   logic        accept;
   logic [29:0] wordOff;
   logic [AW-1:0] idxIn;
   logic        inRange, opLegal, misaligned, reqErr;
   logic [3:0]  byteEn;
   logic [31:0] wrData;
   logic        wrEn, rdEn;
   logic [AW-1:0] rdIdx;

   logic [2:0]  opReg;
   logic [1:0]  laneReg;
   logic [AW-1:0] idxReg;
   logic        errReg, loadReg;
   logic [31:0] readWord, alignedData;

   logic [31:0] mem [DEPTH_WORDS];

   assign req_ready  = (stateReg == IDLE) && !rst;
   assign accept     = req_valid && req_ready;
   assign resp_valid = (stateReg == RESP);
   assign resp_err   = (stateReg == RESP) && errReg;
   assign resp_rdata = ((stateReg == RESP) && loadReg) ? alignedData : '0;

   // ---- request decode (combinational, only meaningful on the accept edge)
   assign wordOff = 30'((req_addr - BASE_ADDR) >> 2);
   assign inRange = (req_addr >= BASE_ADDR) && ({2'b00, wordOff} < 32'(DEPTH_WORDS));
   assign idxIn   = wordOff[AW-1:0];
   assign opLegal = req_re ? is_legal_op(req_op, 1'b0) : is_legal_op(req_op, 1'b1);
   assign misaligned = ((req_op[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_op == MEMOP_W) && (req_addr[1:0] != 2'b00));
   // A request with neither re nor we is a harmless no-op, never a fault.
   assign reqErr = (req_re || req_we) &&
                   ((req_re && req_we) || !inRange || !opLegal || misaligned);

   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byteEn[gi] = (req_op == MEMOP_W) ||
                          ((req_op == MEMOP_H) && (req_addr[1] == 1'(gi / 2))) ||
                          ((req_op == MEMOP_B) && (req_addr[1:0] == 2'(gi)));
      assign wrData[8*gi +: 8] = (req_op == MEMOP_W) ? req_wdata[8*gi +: 8] :
                                 (req_op == MEMOP_H) ? req_wdata[8*(gi%2) +: 8] :
                                                       req_wdata[7:0];
   end

   assign wrEn  = accept && req_we && !reqErr;
   // With LATENCY=1 the word is fetched on the accept edge straight from the
   // incoming address; otherwise on the last WAIT edge from the held index.
   assign rdEn  = (LATENCY == 1) ? (accept && req_re && !reqErr)
                                 : ((stateReg == WAIT) && (cntReg == 4'd1) && loadReg);
   assign rdIdx = (LATENCY == 1) ? idxIn : idxReg;

   always_ff @(posedge clk) begin
      if (wrEn) begin
         for (int b = 0; b < 4; b++) begin
            if (byteEn[b])
               mem[idxIn][8*b +: 8] <= wrData[8*b +: 8];
         end
      end
      if (rdEn)
         readWord <= mem[rdIdx];
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         opReg   <= req_op;
         laneReg <= req_addr[1:0];
         idxReg  <= idxIn;
         errReg  <= reqErr;
         loadReg <= req_re && !reqErr;
      end
   end

   ysyx_25030085_load_align u_align (
      .word (readWord),
      .lane (laneReg),
      .op   (opReg),
      .data (alignedData)
   );

   // ---- control FSM; cnt = cycles left until the response becomes visible
   always_ff @(posedge clk) begin
      if (rst) begin
         stateReg <= IDLE;
         cntReg   <= '0;
      end else begin
         stateReg <= stateNext;
         cntReg   <= cntNext;
      end
   end

   always_comb begin
      stateNext = stateReg;
      cntNext   = cntReg;
      case (stateReg)
         IDLE: begin
            if (accept) begin
               cntNext   = 4'(LATENCY - 1);
               stateNext = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (cntReg == 4'd1) begin
               cntNext   = '0;
               stateNext = RESP;
            end else begin
               cntNext = cntReg - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready)
               stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ysyx_25030085_data_mem_lsu.sv
// Scoreboard bench: instance 0 runs LATENCY=1, instance 1 runs LATENCY=4;
// expected responses are queued at accept and compared at the response handshake.
module tb_ysyx_25030085_data_mem_lsu;
   import ysyx_25030085_mem_pkg::*;

   localparam logic [31:0] BASE = 32'h8000_0000;

   typedef struct packed {
      logic        dut;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic [1:0]       req_valid, req_re, req_we, resp_ready;
   logic [1:0][2:0]  req_op;
   logic [1:0][31:0] req_addr, req_wdata;
   wire  [1:0]       req_ready, resp_valid, resp_err;
   wire  [1:0][31:0] resp_rdata;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];
   bit   rand_ready = 1'b0;
   logic [31:0] sdata [16];

   always #5 clk = ~clk;

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_dut
      ysyx_25030085_data_mem_lsu #(
         .DEPTH_WORDS (65536),
         .BASE_ADDR   (BASE),
         .LATENCY     ((gi == 0) ? 1 : 4)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .req_valid  (req_valid[gi]),
         .req_ready  (req_ready[gi]),
         .req_re     (req_re[gi]),
         .req_we     (req_we[gi]),
         .req_op     (req_op[gi]),
         .req_addr   (req_addr[gi]),
         .req_wdata  (req_wdata[gi]),
         .resp_valid (resp_valid[gi]),
         .resp_ready (resp_ready[gi]),
         .resp_rdata (resp_rdata[gi]),
         .resp_err   (resp_err[gi])
      );
   end

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 4;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Called just after a posedge; returns just after the accept edge.
   task automatic issue(input int d, input logic re, input logic we, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input bit push);
      int k = 0;
      req_valid[d] = 1'b1;
      req_re[d]    = re;
      req_we[d]    = we;
      req_op[d]    = op;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      @(negedge clk);
      while (!req_ready[d] && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!req_ready[d]) begin
         check_val("accept_timeout", 32'(req_ready[d]), 32'd1);
         req_valid[d] = 1'b0;
         @(posedge clk); #1;
         return;
      end
      @(posedge clk); #1;
      if (push) sb_q.push_back('{dut: 1'(d), rdata: exp_rdata, err: exp_err});
      // Scramble the request bus: the DUT must have latched everything at accept.
      req_valid[d] = 1'b0;
      req_re[d]    = 1'($urandom);
      req_we[d]    = 1'($urandom);
      req_op[d]    = 3'($urandom);
      req_addr[d]  = $urandom;
      req_wdata[d] = $urandom;
   endtask

   task automatic wait_resp(input int d);
      int lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid[d] && lat < 40);
      check_val("resp_latency", 32'(lat), 32'(lat_of(d)));
   endtask

   task automatic finish_resp(input int d);
      int k = 0;
      while (resp_valid[d] && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (resp_valid[d]) check_val("resp_drain", 32'(resp_valid[d]), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic xact(input int d, input logic re, input logic we, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
      issue(d, re, we, op, addr, wdata, exp_rdata, exp_err, 1'b1);
      wait_resp(d);
      finish_resp(d);
   endtask

   // Response monitor: a response is consumed at the next posedge when valid && ready.
   always @(negedge clk) begin
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            if (resp_valid[d] && resp_ready[d]) begin
               $display("resp dut%0d rdata=%08h err=%0b", d, resp_rdata[d], resp_err[d]);
               if (sb_q.size() == 0) begin
                  check_val("sb_unexpected_resp", 32'(resp_valid[d]), 32'd0);
               end else begin
                  exp_t e;
                  e = sb_q.pop_front();
                  check_val("resp_dut", 32'(d), 32'(e.dut));
                  check_val("resp_rdata", resp_rdata[d], e.rdata);
                  check_val("resp_err", 32'(resp_err[d]), 32'(e.err));
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_ready) resp_ready = 2'($urandom);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      req_valid = '0; req_re = '0; req_we = '0; req_op = '0;
      req_addr = '0; req_wdata = '0; resp_ready = 2'b11;

      // ---- reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check_val("rst_req_ready", 32'(req_ready[d]), 32'd0);
         check_val("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
         check_val("rst_resp_rdata", resp_rdata[d], 32'd0);
         check_val("rst_resp_err", 32'(resp_err[d]), 32'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) check_val("post_rst_req_ready", 32'(req_ready[d]), 32'd1);
      @(posedge clk); #1;

      // ---- LATENCY=1: store/load, sub-word extension, lane preservation
      xact(0, 0, 1, MEMOP_W,  32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 0);
      xact(0, 1, 0, MEMOP_W,  32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0);
      xact(0, 0, 1, MEMOP_W,  32'h8000_0020, 32'h1122_3344, 32'h0, 0);
      xact(0, 0, 1, MEMOP_B,  32'h8000_0021, 32'hABCD_EF80, 32'h0, 0);
      xact(0, 1, 0, MEMOP_B,  32'h8000_0021, 32'h0, 32'hFFFF_FF80, 0);
      xact(0, 1, 0, MEMOP_BU, 32'h8000_0021, 32'h0, 32'h0000_0080, 0);
      xact(0, 1, 0, MEMOP_W,  32'h8000_0020, 32'h0, 32'h1122_8044, 0);
      xact(0, 0, 1, MEMOP_H,  32'h8000_0022, 32'h1234_8001, 32'h0, 0);
      xact(0, 1, 0, MEMOP_H,  32'h8000_0022, 32'h0, 32'hFFFF_8001, 0);
      xact(0, 1, 0, MEMOP_HU, 32'h8000_0022, 32'h0, 32'h0000_8001, 0);
      xact(0, 1, 0, MEMOP_W,  32'h8000_0020, 32'h0, 32'h8001_8044, 0);
      xact(0, 1, 0, MEMOP_B,  32'h8000_0023, 32'h0, 32'hFFFF_FF80, 0);
      xact(0, 1, 0, MEMOP_BU, 32'h8000_0020, 32'h0, 32'h0000_0044, 0);

      // ---- faults
      xact(0, 0, 1, MEMOP_W,  32'h8000_0000, 32'h0BAD_F00D, 32'h0, 0);
      xact(0, 1, 0, MEMOP_W,  32'h8000_0002, 32'h0, 32'h0, 1);
      xact(0, 0, 1, MEMOP_H,  32'h8000_0001, 32'h0000_FFFF, 32'h0, 1);
      xact(0, 1, 0, MEMOP_W,  32'h8000_0000, 32'h0, 32'h0BAD_F00D, 0);
      xact(0, 1, 0, MEMOP_W,  32'h7FFF_FFFC, 32'h0, 32'h0, 1);
      xact(0, 1, 0, 3'b011,   32'h8000_0010, 32'h0, 32'h0, 1);
      xact(0, 1, 1, MEMOP_W,  32'h8000_0010, 32'h5555_5555, 32'h0, 1);
      xact(0, 0, 1, MEMOP_BU, 32'h8000_0010, 32'h5555_5555, 32'h0, 1);
      xact(0, 1, 0, MEMOP_W,  32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0);
      xact(0, 1, 0, MEMOP_W,  32'h8004_0000, 32'h0, 32'h0, 1);
      xact(0, 0, 1, MEMOP_W,  32'h8003_FFFC, 32'h5A5A_5A5A, 32'h0, 0);
      xact(0, 1, 0, MEMOP_W,  32'h8003_FFFC, 32'h0, 32'h5A5A_5A5A, 0);
      xact(0, 0, 0, MEMOP_W,  32'h8000_0010, 32'hFFFF_FFFF, 32'h0, 0);

      // ---- LATENCY=4 with backpressure
      xact(1, 0, 1, MEMOP_W, 32'h8000_0100, 32'h1234_5678, 32'h0, 0);
      xact(1, 1, 0, MEMOP_W, 32'h8000_0100, 32'h0, 32'h1234_5678, 0);
      resp_ready[1] = 1'b0;
      issue(1, 1, 0, MEMOP_W, 32'h8000_0100, 32'h0, 32'h1234_5678, 0, 1'b1);
      wait_resp(1);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         check_val("bp_resp_valid", 32'(resp_valid[1]), 32'd1);
         check_val("bp_resp_rdata", resp_rdata[1], 32'h1234_5678);
         check_val("bp_req_ready", 32'(req_ready[1]), 32'd0);
      end
      @(posedge clk); #1;
      resp_ready[1] = 1'b1;
      finish_resp(1);

      // ---- reset two cycles after a load accept
      xact(1, 0, 1, MEMOP_W, 32'h8000_0200, 32'hCAFE_F00D, 32'h0, 0);
      issue(1, 1, 0, MEMOP_W, 32'h8000_0200, 32'h0, 32'h0, 0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check_val("rst_mid_req_ready", 32'(req_ready[1]), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("rst_mid_resp_valid", 32'(resp_valid[1]), 32'd0);
         check_val("rst_mid_idle_ready", 32'(req_ready[1]), 32'd1);
      end
      @(posedge clk); #1;
      xact(1, 1, 0, MEMOP_W, 32'h8000_0200, 32'h0, 32'hCAFE_F00D, 0);

      // ---- back-to-back streaming with random consumer backpressure
      for (int d = 0; d < 2; d++) begin
         int k;
         rand_ready = 1'b1;
         for (int i = 0; i < 16; i++) begin
            sdata[i] = $urandom;
            issue(d, 0, 1, MEMOP_W, BASE + 32'h1000 + 32'(4 * i), sdata[i], 32'h0, 0, 1'b1);
         end
         for (int i = 0; i < 16; i++)
            issue(d, 1, 0, MEMOP_W, BASE + 32'h1000 + 32'(4 * i), 32'h0, sdata[i], 0, 1'b1);
         k = 0;
         @(negedge clk);
         while (sb_q.size() != 0 && k < 500) begin
            @(negedge clk);
            k++;
         end
         check_val("stream_drain", 32'(sb_q.size()), 32'd0);
         rand_ready = 1'b0;
         @(posedge clk); #1;
         resp_ready = 2'b11;
         repeat (3) @(posedge clk);
         #1;
      end

      check_val("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
